// File: rtl/posit_pkg.sv
// Shared definitions for the posit decoder.
//   fw_of / sw_of  : fraction and scale widths derived from (N, ES)
//   nar_pattern    : the NaR bit pattern for an n-bit posit
//   ZERO_PATTERN   : the all-zero pattern (zero value)
//   decoded_t      : decoded fields at the widest supported size (N=32, ES<=3)
package posit_pkg;

  localparam int MAX_N = 32;

  function automatic int fw_of(input int n, input int es);
    return n - 3 - es;
  endfunction

  function automatic int sw_of(input int n, input int es);
    return $clog2((n - 1) << es) + 1;
  endfunction

  // Widest fraction comes from N=32/ES=0, widest scale from N=32/ES=3.
  localparam int MAX_FW = fw_of(MAX_N, 0);
  localparam int MAX_SW = sw_of(MAX_N, 3);

  localparam logic [MAX_N-1:0] ZERO_PATTERN = '0;

  function automatic logic [MAX_N-1:0] nar_pattern(input int n);
    return MAX_N'(1) << (n - 1);
  endfunction

  typedef struct packed {
    logic                     sign;
    logic                     zero;
    logic                     inf;
    logic signed [MAX_SW-1:0] scale;
    logic [MAX_FW-1:0]        frac;
  } decoded_t;

endpackage

// File: rtl/posit_decode_pipe_if.sv
// Handshake bundle between the operand side, the decoder and the datapath.
//   in_valid/in_ready/in_posit  : one posit per accepted cycle
//   out_valid/out_ready         : decoded result handshake
//   out_sign/zero/inf/scale/frac: decoded fields
// master = environment (drives inputs, consumes outputs), slave = decoder.
interface posit_decode_pipe_if import posit_pkg::*; #(
  parameter int N  = 8,
  parameter int ES = 0
) ();

  localparam int FW = fw_of(N, ES);
  localparam int SW = sw_of(N, ES);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_posit;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic          out_zero;
  logic          out_inf;
  logic [SW-1:0] out_scale;
  logic [FW-1:0] out_frac;

  modport master (
    output in_valid, in_posit, out_ready,
    input  in_ready, out_valid, out_sign, out_zero, out_inf, out_scale, out_frac
  );

  modport slave (
    input  in_valid, in_posit, out_ready,
    output in_ready, out_valid, out_sign, out_zero, out_inf, out_scale, out_frac
  );

endinterface

// File: rtl/posit_regime_count.sv
// Combinational leading-run counter.
//   bits    : W-bit vector, run starts at the MSB
//   run_bit : value of the MSB (the bit being repeated)
//   run_len : number of consecutive bits equal to run_bit from the MSB (1..W)
module posit_regime_count #(
  parameter int W = 7
) (
  input  logic [W-1:0]             bits,
  output logic                     run_bit,
  output logic [$clog2(W+1)-1:0]   run_len
);

  localparam int CW = $clog2(W + 1);

  logic stop;

  assign run_bit = bits[W-1];

  // NOTE: every variable written here gets a default before the loop, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    run_len = '0;
    stop    = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!stop && (bits[i] == run_bit)) run_len = run_len + CW'(1);
      else                               stop    = 1'b1;
    end
  end

endmodule

// File: rtl/posit_decode_pipe.sv
// Two-stage pipelined posit decoder.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : posit_decode_pipe_if slave port (valid/ready in, valid/ready out,
//                decoded sign, zero, NaR, signed scale, MSB-aligned fraction)
// S1 takes the magnitude and measures the regime run; S2 strips regime and
// terminator, extracts exponent and fraction and forms the scale.
module posit_decode_pipe import posit_pkg::*; #(
  parameter int N  = 8,
  parameter int ES = 0
) (
  input logic               clk,
  input logic               rst_n,
  posit_decode_pipe_if.slave bus
);

  localparam int FW = fw_of(N, ES);
  localparam int SW = sw_of(N, ES);
  localparam int W  = N - 1;          // bits below the sign
  localparam int MW = $clog2(N);      // holds run lengths 1..N-1

  localparam logic [N-1:0] NAR_PAT  = N'(nar_pattern(N));
  localparam logic [N-1:0] ZERO_PAT = N'(ZERO_PATTERN);

  // ---------------- handshake ----------------
  logic s1_valid, s2_valid;
  logic s2_free, s2_load, s1_load;

  assign s2_free      = !s2_valid || bus.out_ready;
  assign s2_load      = s1_valid && s2_free;
  assign bus.in_ready = !s1_valid || s2_load;
  assign s1_load      = bus.in_valid && bus.in_ready;

  // ---------------- S1: magnitude and regime run ----------------
  logic          in_sign;
  logic [W-1:0]  in_mag;
  logic          run_bit;
  logic [MW-1:0] run_len;

  assign in_sign = bus.in_posit[N-1];
  // Low bits of a two's complement negation depend only on low input bits,
  // so the magnitude is formed directly at W bits.
  assign in_mag  = in_sign ? (~bus.in_posit[W-1:0] + W'(1)) : bus.in_posit[W-1:0];

  posit_regime_count #(.W(W)) u_regime (
    .bits    (in_mag),
    .run_bit (run_bit),
    .run_len (run_len)
  );

  logic [W-1:0]  s1_mag;
  logic [MW-1:0] s1_len;
  logic          s1_run, s1_sign, s1_zero, s1_inf;

  // ---------------- S2: strip regime, split exponent / fraction ----------------
  logic [MW:0]          shamt;
  logic [W-1:0]         body;
  logic [SW-1:0]        e_ext;
  logic [FW-1:0]        frac;
  logic signed [SW-1:0] len_s, k, scale;
  decoded_t             s2_d, s2_q;

  // One extra bit so a full-width run (shift of N) clears the body.
  assign shamt = {1'b0, s1_len} + (MW+1)'(1);
  assign body  = s1_mag << shamt;

  if (ES > 0) begin : g_exp
    assign e_ext = SW'(body[W-1 -: ES]);
  end else begin : g_no_exp
    assign e_ext = '0;
  end

  assign frac  = body[W-1-ES -: FW];
  // len can equal 2^(SW-1) for some N; modular arithmetic still yields the
  // right k in both branches.
  assign len_s = SW'(s1_len);
  assign k     = s1_run ? (len_s - SW'(1)) : -len_s;
  assign scale = (k <<< ES) + e_ext;

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_sign;
    s2_d.zero = s1_zero;
    s2_d.inf  = s1_inf;
    if (!s1_zero && !s1_inf) begin
      s2_d.scale = MAX_SW'(scale);
      s2_d.frac  = MAX_FW'(frac);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_mag   <= '0;
      s1_len   <= '0;
      s1_run   <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_inf   <= 1'b0;
      s2_q     <= '0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (s1_load) begin
        s1_mag  <= in_mag;
        s1_len  <= run_len;
        s1_run  <= run_bit;
        s1_sign <= in_sign;
        s1_zero <= (bus.in_posit == ZERO_PAT);
        s1_inf  <= (bus.in_posit == NAR_PAT);
      end
      if (s2_free) s2_valid <= s1_valid;
      if (s2_load) s2_q     <= s2_d;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_sign  = s2_q.sign;
  assign bus.out_zero  = s2_q.zero;
  assign bus.out_inf   = s2_q.inf;
  assign bus.out_scale = s2_q.scale[SW-1:0];
  assign bus.out_frac  = s2_q.frac[FW-1:0];

  // Upper struct bits are constant for narrow configurations and the two
  // lowest body bits are always shifted-in zeros; read them here so they
  // are visibly intentional.
  logic unused_bits;
  assign unused_bits = ^{s2_q.scale, s2_q.frac, body[1:0]};

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Directed bench for posit_decode_pipe: N=8/ES=0 and N=16/ES=2 instances.
module tb_posit_decode_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  posit_decode_pipe_if #(.N(8),  .ES(0)) b8  ();
  posit_decode_pipe_if #(.N(16), .ES(2)) b16 ();

  posit_decode_pipe #(.N(8),  .ES(0)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  posit_decode_pipe #(.N(16), .ES(2)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  typedef struct packed {
    logic        sign;
    logic        zero;
    logic        inf;
    logic [31:0] scale;
    logic [31:0] frac;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t nxt8, nxt16;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out8 = 0;
  int   n_out16 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp8(input string tag, input exp_t e);
    check({tag, ".sign"},  32'(b8.out_sign),  32'(e.sign));
    check({tag, ".zero"},  32'(b8.out_zero),  32'(e.zero));
    check({tag, ".inf"},   32'(b8.out_inf),   32'(e.inf));
    check({tag, ".scale"}, 32'(b8.out_scale), e.scale);
    check({tag, ".frac"},  32'(b8.out_frac),  e.frac);
  endtask

  task automatic cmp16(input string tag, input exp_t e);
    check({tag, ".sign"},  32'(b16.out_sign),  32'(e.sign));
    check({tag, ".zero"},  32'(b16.out_zero),  32'(e.zero));
    check({tag, ".inf"},   32'(b16.out_inf),   32'(e.inf));
    check({tag, ".scale"}, 32'(b16.out_scale), e.scale);
    check({tag, ".frac"},  32'(b16.out_frac),  e.frac);
  endtask

  task automatic present8(input logic [7:0] p, input logic s, input logic z, input logic i,
                          input logic [31:0] sc, input logic [31:0] fr);
    b8.in_valid = 1'b1;
    b8.in_posit = p;
    nxt8 = '{s, z, i, sc, fr};
  endtask

  task automatic present16(input logic [15:0] p, input logic s, input logic z, input logic i,
                           input logic [31:0] sc, input logic [31:0] fr);
    b16.in_valid = 1'b1;
    b16.in_posit = p;
    nxt16 = '{s, z, i, sc, fr};
  endtask

  // Called at posedge+1: scores outputs taken at the coming edge, records
  // accepted inputs, returns at the next posedge+1.
  task automatic tick();
    logic acc8, acc16;
    exp_t e;
    #1;
    if (b8.out_valid && b8.out_ready) begin
      n_out8++;
      check("out8_expected", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        cmp8("out8", e);
      end
    end
    if (b16.out_valid && b16.out_ready) begin
      n_out16++;
      check("out16_expected", 32'(q16.size() != 0), 32'd1);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        cmp16("out16", e);
      end
    end
    acc8  = b8.in_valid && b8.in_ready;
    acc16 = b16.in_valid && b16.in_ready;
    @(posedge clk);
    #1;
    if (acc8)  q8.push_back(nxt8);
    if (acc16) q16.push_back(nxt16);
  endtask

  initial begin
    rst_n         = 1'b0;
    b8.in_valid   = 1'b0;
    b8.in_posit   = '0;
    b8.out_ready  = 1'b1;
    b16.in_valid  = 1'b0;
    b16.in_posit  = '0;
    b16.out_ready = 1'b1;
    nxt8  = '0;
    nxt16 = '0;

    // ---- reset state ----
    @(posedge clk);
    #1;
    check("rst.out_valid", 32'(b8.out_valid), 32'd0);
    check("rst.in_ready",  32'(b8.in_ready),  32'd1);
    check("rst.scale",     32'(b8.out_scale), 32'd0);
    check("rst.frac",      32'(b8.out_frac),  32'd0);
    check("rst.flags",     32'({b8.out_sign, b8.out_zero, b8.out_inf}), 32'd0);
    check("rst16.out_valid", 32'(b16.out_valid), 32'd0);
    rst_n = 1'b1;

    // ---- N=8 directed stream, with latency check ----
    present8(8'h00, 0, 1, 0, 32'h0, 32'h0);
    tick();
    check("lat.cycle1", 32'(b8.out_valid), 32'd0);
    present8(8'h80, 1, 0, 1, 32'h0, 32'h0);
    tick();
    check("lat.cycle2", 32'(b8.out_valid), 32'd1);
    present8(8'h76, 0, 0, 0, 32'h2, 32'b11000); tick();
    present8(8'h16, 0, 0, 0, 32'hE, 32'b01100); tick();
    present8(8'h57, 0, 0, 0, 32'h0, 32'b10111); tick();
    present8(8'h40, 0, 0, 0, 32'h0, 32'h0);     tick();
    present8(8'h8a, 1, 0, 0, 32'h2, 32'b11000); tick();
    present8(8'h7f, 0, 0, 0, 32'h6, 32'h0);     tick();
    present8(8'h01, 0, 0, 0, 32'hA, 32'h0);     tick();
    b8.in_valid = 1'b0;
    repeat (3) tick();

    // ---- N=16, ES=2 ----
    present16(16'h5a00, 0, 0, 0, 32'd3,  32'b01000000000); tick();
    present16(16'ha600, 1, 0, 0, 32'd3,  32'b01000000000); tick();
    present16(16'h7fff, 0, 0, 0, 32'd56, 32'h0);           tick();
    present16(16'h0001, 0, 0, 0, 32'h48, 32'h0);           tick();
    present16(16'h8000, 1, 0, 1, 32'h0,  32'h0);           tick();
    present16(16'h7ffd, 0, 0, 0, 32'd50, 32'h0);           tick();
    b16.in_valid = 1'b0;
    repeat (3) tick();

    // ---- back-pressure: 6 items, 4-cycle stall with both stages full ----
    present8(8'h76, 0, 0, 0, 32'h2, 32'b11000); tick();
    present8(8'h16, 0, 0, 0, 32'hE, 32'b01100); tick();
    b8.out_ready = 1'b0;
    present8(8'h57, 0, 0, 0, 32'h0, 32'b10111);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("stall.in_ready",  32'(b8.in_ready),  32'd0);
      check("stall.out_valid", 32'(b8.out_valid), 32'd1);
      check("stall.depth",     32'(q8.size()),    32'd2);
      if (q8.size() != 0) cmp8("stall.hold", q8[0]);
    end
    b8.out_ready = 1'b1;
    tick();
    present8(8'h8a, 1, 0, 0, 32'h2, 32'b11000); tick();
    present8(8'h7f, 0, 0, 0, 32'h6, 32'h0);     tick();
    present8(8'h01, 0, 0, 0, 32'hA, 32'h0);     tick();
    b8.in_valid = 1'b0;
    repeat (3) tick();

    check("count.out8",  32'(n_out8),     32'd15);
    check("count.out16", 32'(n_out16),    32'd6);
    check("drained8",    32'(q8.size()),  32'd0);
    check("drained16",   32'(q16.size()), 32'd0);

    // ---- asynchronous reset with both stages full ----
    b8.out_ready = 1'b0;
    present8(8'h76, 0, 0, 0, 32'h2, 32'b11000); tick();
    present8(8'h16, 0, 0, 0, 32'hE, 32'b01100); tick();
    b8.in_valid = 1'b0;
    check("prerst.out_valid", 32'(b8.out_valid), 32'd1);
    check("prerst.in_ready",  32'(b8.in_ready),  32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", 32'(b8.out_valid), 32'd0);
    check("midrst.in_ready",  32'(b8.in_ready),  32'd1);
    check("midrst.scale",     32'(b8.out_scale), 32'd0);
    check("midrst.frac",      32'(b8.out_frac),  32'd0);
    check("midrst.flags",     32'({b8.out_sign, b8.out_zero, b8.out_inf}), 32'd0);
    q8.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b8.out_ready = 1'b1;
    check("postrst.in_ready", 32'(b8.in_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("postrst.no_out", 32'(b8.out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
